matrix_result_sender: RTL and testbench
=======================================

// Module: matrix_result_sender
// PURPOSE
//  Transmit side of the matrix Ethernet link; counterpart of the dibit matrix loader.
//  - Reads a MATRIX_DIM x MATRIX_DIM result matrix row-by-row from a result BRAM.
//  - Serialises it onto a 2-bit stream (axiov/axiod) in the same element and dibit order the loader consumes.
//  - Sits between the result buffer (read port on eth_refclk) and the Ethernet TX framer.
// PARAMETERS
//  ELEMENT_WIDTH   8   bits per element; must be even
//  MATRIX_DIM      32  rows, and elements per row
//  RD_LATENCY      2   cycles from row_rd_en to row_data valid (BRAM HIGH_PERFORMANCE)
// PORTS
//  eth_refclk  in   1                        clock; all logic in this domain
//  rst         in   1                        reset: synchronous, active-high
//  start       in   1                        1-cycle pulse: begin sending the matrix
//  row_rd_en   out  1                        1-cycle read strobe to result BRAM
//  row_addr    out  $clog2(MATRIX_DIM)       row index being read
//  row_data    in   MATRIX_DIM*ELEMENT_WIDTH row word, valid RD_LATENCY cycles after row_rd_en
//  axiov       out  1                        output dibit valid
//  axiod       out  2                        output dibit
//  busy        out  1                        high from accepted start until done
//  done        out  1                        1-cycle pulse after the last dibit
// BEHAVIOUR
//  - Reset values: axiov=0, axiod=0, row_rd_en=0, row_addr=0, busy=0, done=0; FSM=IDLE.
//  - Ordering:
//    - rows 0..MATRIX_DIM-1.
//    - Element k of a row is row_data[W-1-k*E -: E], where W=MATRIX_DIM*ELEMENT_WIDTH and E=ELEMENT_WIDTH.
//    - Each element goes MSB dibit first: [E-1:E-2] ... [1:0].
//  - FSM:
//    - IDLE: on start, pulse row_rd_en with row_addr=0, set busy -> PRIME.
//    - PRIME: wait RD_LATENCY cycles; capture row_data into the shift register -> SEND.
//    - SEND: one dibit per cycle with axiov=1.
//      - On the first SEND cycle of row r (r<MATRIX_DIM-1), issue the read of row r+1.
//      - Capture row r+1 into a holding register on arrival.
//      - After the last dibit of a row, the holding register loads the shifter with no gap cycle.
//      - After the last dibit of the last row: go to CKSUM if CHECKSUM_EN is defined, otherwise DONE.
//    - CKSUM (optional): see CONFIGURATION.
//    - DONE: axiov=0, busy=0, done=1 for one cycle -> IDLE.
//  - Stream timing:
//    - axiov is continuous; it never drops mid-matrix.
//    - First valid dibit appears RD_LATENCY+2 cycles after start is sampled.
//    - Defaults: exactly MATRIX_DIM*MATRIX_DIM*E/2 = 4096 valid dibits.
//  - Counters:
//    - dibit counter, E/2 per element, wraps per element.
//    - element counter, wraps per row.
//    - row counter, terminal at MATRIX_DIM-1.
//    - Widths from $clog2; no unused wrap states.
//  - Boundary conditions:
//    - start while busy: ignored; no restart, no output glitch.
//    - start coincident with rst: rst wins.
//    - rst mid-transfer: outputs return to reset values at the next edge. The stream is truncated; the framer discards it.
//    - row_data outside its capture cycles: ignored.
//    - MATRIX_DIM=1: no prefetch read is issued.
// CONFIGURATION
//  - Macro MATRIX_SENDER_CHECKSUM_EN, defined:
//    - an 8-bit running sum (mod 256) of all transmitted elements, cleared on start;
//    - after the last element, 4 further dibits carry the sum, MSB dibit first;
//    - axiov stays contiguous (4100 dibits total at defaults), then DONE.
//  - Not defined: no CKSUM state, no adder; SEND -> DONE directly.
// STRUCTURE
//  - Shared package matrix_pkg:
//    - ELEMENT_WIDTH and MATRIX_DIM defaults;
//    - sender_state_t enum {IDLE, PRIME, SEND, CKSUM, DONE};
//    - localparam DIBITS_PER_ELEM = ELEMENT_WIDTH/2.
//  - Sub-module row_serializer: row-wide shift register plus holding register and dibit/element counters.
//    - Input: load strobe.
//    - Outputs: dibit and last-dibit-of-row flag.
//  - Top level keeps the FSM, the BRAM read sequencing and the optional checksum.
// TESTING
//  - Full matrix: BRAM model with element(r,k) = (r*32+k) mod 256, start pulse
//    -> 4096 contiguous dibits. Re-assembling dibits yields 0x00,0x01,...,0xFF,0x00,...; done pulses once; busy falls with done.
//  - Dibit order: row 0 = {0xC6, 0, ...}
//    -> first four axiod = 2'b11, 2'b00, 2'b01, 2'b10.
//  - Latency/prefetch: RD_LATENCY=2
//    -> first axiov 4 cycles after start; row_rd_en row 1 on cycle 1 of row 0; no axiov gap at every row boundary (128, 256, ...).
//  - start asserted again at dibit 1000
//    -> ignored; stream identical to the golden trace.
//  - rst at dibit 2000
//    -> next cycle axiov=0, busy=0, done=0. A new start then sends a full, correct matrix.
//  - MATRIX_SENDER_CHECKSUM_EN with all elements 0x01
//    -> 4 trailer dibits = 0x00 (1024 mod 256), total 4100 valid; all elements 0x03 -> trailer 0x00; one element 0x05, rest 0 -> trailer 0x05.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared sizes, sender state encoding and a counter-width helper for the matrix link.
package matrix_pkg;
  localparam int ELEMENT_WIDTH = 8;
  localparam int MATRIX_DIM = 32;
  localparam int DIBITS_PER_ELEM = ELEMENT_WIDTH / 2;
  typedef enum logic [2:0] {IDLE, PRIME, SEND, CKSUM, DONE} sender_state_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/matrix_result_sender_if.sv
// matrix_result_sender_if: control, result-BRAM read port and dibit stream of the matrix sender.
interface matrix_result_sender_if #(
  parameter int ELEMENT_WIDTH = matrix_pkg::ELEMENT_WIDTH,
  parameter int MATRIX_DIM = matrix_pkg::MATRIX_DIM
) ();
  logic start;
  logic busy;
  logic done;
  logic row_rd_en;
  logic [matrix_pkg::cw(MATRIX_DIM)-1:0] row_addr;
  logic [MATRIX_DIM*ELEMENT_WIDTH-1:0] row_data;
  logic axiov;
  logic [1:0] axiod;
  modport master(input start, row_data, output busy, done, row_rd_en, row_addr, axiov, axiod);
  modport slave(output start, row_data, input busy, done, row_rd_en, row_addr, axiov, axiod);
endinterface

// File: rtl/matrix_result_sender_row_serializer.sv
// row_serializer: row-wide dibit shifter with a holding register that reloads it gaplessly at row end.
// Element-start outputs exist only when MATRIX_SENDER_CHECKSUM_EN is defined.
module row_serializer #(
  parameter int ELEMENT_WIDTH = matrix_pkg::ELEMENT_WIDTH,
  parameter int MATRIX_DIM = matrix_pkg::MATRIX_DIM
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic capture,
  input logic shift,
  input logic [MATRIX_DIM*ELEMENT_WIDTH-1:0] row_data,
  output logic [1:0] dibit,
  output logic last
`ifdef MATRIX_SENDER_CHECKSUM_EN
  ,
  output logic elem_first,
  output logic [ELEMENT_WIDTH-1:0] head
`endif
);
  import matrix_pkg::*;
  localparam int W = MATRIX_DIM * ELEMENT_WIDTH;
  localparam int DPE = ELEMENT_WIDTH / 2;
  logic [W-1:0] sr, hold;
  logic [cw(DPE)-1:0] dcnt;
  logic [cw(MATRIX_DIM)-1:0] ecnt;
  logic d_wrap;
  assign d_wrap = int'(dcnt) == DPE - 1;
  assign last = d_wrap && int'(ecnt) == MATRIX_DIM - 1;
  assign dibit = sr[W-1 -: 2];
`ifdef MATRIX_SENDER_CHECKSUM_EN
  assign elem_first = dcnt == '0;
  assign head = sr[W-1 -: ELEMENT_WIDTH];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      hold <= '0;
      dcnt <= '0;
      ecnt <= '0;
    end else begin
      if (capture) hold <= row_data;
      if (load) begin
        sr <= row_data;
        dcnt <= '0;
        ecnt <= '0;
      end else if (shift) begin
        sr <= last ? hold : sr << 2;
        dcnt <= d_wrap ? '0 : dcnt + 1'b1;
        ecnt <= d_wrap ? (last ? '0 : ecnt + 1'b1) : ecnt;
      end
    end
  end
endmodule

// File: rtl/matrix_result_sender.sv
// matrix_result_sender: reads the result matrix row by row from BRAM and streams it as contiguous dibits.
// Define MATRIX_SENDER_CHECKSUM_EN to append an 8-bit element sum as four trailer dibits.
module matrix_result_sender #(
  parameter int ELEMENT_WIDTH = matrix_pkg::ELEMENT_WIDTH,
  parameter int MATRIX_DIM = matrix_pkg::MATRIX_DIM,
  parameter int RD_LATENCY = 2
) (
  input logic eth_refclk,
  input logic rst,
  matrix_result_sender_if.master bus
);
  import matrix_pkg::*;
  localparam int RW = cw(MATRIX_DIM);
  sender_state_t state;
  logic [RW-1:0] row_cnt;
  logic [RD_LATENCY-1:0] rd_dly;
  logic [1:0] dibit;
  logic last, arrive, last_row;
  assign arrive = rd_dly[RD_LATENCY-1];
  assign last_row = int'(row_cnt) == MATRIX_DIM - 1;
`ifdef MATRIX_SENDER_CHECKSUM_EN
  logic elem_first;
  logic [ELEMENT_WIDTH-1:0] head;
  logic [7:0] sum, ck, sum_nx;
  logic [1:0] ck_cnt;
  assign sum_nx = sum + (elem_first ? 8'(head) : 8'd0);
  // ck tracks the running sum while sending so it already holds the total on entering CKSUM
  always_ff @(posedge eth_refclk) begin
    if (rst || state == IDLE) begin
      sum <= '0;
      ck <= '0;
      ck_cnt <= '0;
    end else if (state == SEND) begin
      sum <= sum_nx;
      ck <= sum_nx;
    end else if (state == CKSUM) begin
      ck <= ck << 2;
      ck_cnt <= ck_cnt + 1'b1;
    end
  end
`endif
  row_serializer #(.ELEMENT_WIDTH(ELEMENT_WIDTH), .MATRIX_DIM(MATRIX_DIM)) u_ser (
    .clk(eth_refclk),
    .rst(rst),
    .load(state == PRIME && arrive),
    .capture(state == SEND && arrive),
    .shift(state == SEND),
    .row_data(bus.row_data),
    .dibit(dibit),
    .last(last)
`ifdef MATRIX_SENDER_CHECKSUM_EN
    ,
    .elem_first(elem_first),
    .head(head)
`endif
  );
  // rd_dly marks the cycle a read's data is on row_data, for both the prime and the prefetch reads
  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      state <= IDLE;
      row_cnt <= '0;
      rd_dly <= '0;
      bus.row_rd_en <= 1'b0;
      bus.row_addr <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.axiov <= 1'b0;
      bus.axiod <= '0;
    end else begin
      rd_dly <= RD_LATENCY'({rd_dly, bus.row_rd_en});
      bus.row_rd_en <= 1'b0;
      bus.done <= 1'b0;
      bus.axiov <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.row_rd_en <= 1'b1;
          bus.row_addr <= '0;
          bus.busy <= 1'b1;
          row_cnt <= '0;
          state <= PRIME;
        end
        PRIME: if (arrive) begin
          state <= SEND;
          if (MATRIX_DIM > 1) begin
            bus.row_rd_en <= 1'b1;
            bus.row_addr <= RW'(1);
          end
        end
        SEND: begin
          bus.axiov <= 1'b1;
          bus.axiod <= dibit;
          if (last) begin
            if (!last_row) row_cnt <= row_cnt + 1'b1;
            if (int'(row_cnt) + 2 < MATRIX_DIM) begin
              bus.row_rd_en <= 1'b1;
              bus.row_addr <= RW'(int'(row_cnt) + 2);
            end
`ifdef MATRIX_SENDER_CHECKSUM_EN
            if (last_row) state <= CKSUM;
`else
            if (last_row) state <= DONE;
`endif
          end
        end
`ifdef MATRIX_SENDER_CHECKSUM_EN
        CKSUM: begin
          bus.axiov <= 1'b1;
          bus.axiod <= ck[7:6];
          if (ck_cnt == 2'd3) state <= DONE;
        end
`endif
        DONE: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_result_sender.sv
// tb_matrix_result_sender: randomized scoreboard bench with a BRAM model and a dibit-stream reference.
module tb_matrix_result_sender;
  import matrix_pkg::*;
  localparam int E = ELEMENT_WIDTH;
  localparam int D = MATRIX_DIM;
  localparam int W = D * E;
  localparam int DPE = E / 2;
  localparam int LAT = 2;

  logic eth_refclk = 1'b0;
  logic rst = 1'b1;
  always #5 eth_refclk = ~eth_refclk;

  matrix_result_sender_if #(.ELEMENT_WIDTH(E), .MATRIX_DIM(D)) bus ();
  matrix_result_sender #(.ELEMENT_WIDTH(E), .MATRIX_DIM(D), .RD_LATENCY(LAT)) dut (
    .eth_refclk(eth_refclk),
    .rst(rst),
    .bus(bus)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rd_exp = 0;
  int rd1_c = -1;
  logic [1:0] exp_q[$];
  logic [E-1:0] mem[D][D];

  function automatic void check(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // BRAM model: data valid for exactly one cycle, LAT cycles after the read strobe; junk otherwise
  logic v1 = 1'b0;
  logic [cw(D)-1:0] a1 = '0;
  always @(posedge eth_refclk) begin
    cyc <= cyc + 1;
    v1 <= bus.row_rd_en;
    a1 <= bus.row_addr;
    for (int k = 0; k < D; k++)
      bus.row_data[W-1-k*E -: E] <= v1 ? mem[a1][k] : E'($urandom);
  end

  // Monitor: pops the reference stream on every valid dibit and checks read addresses in order
  always @(negedge eth_refclk) begin
    if (!rst) begin
      if (bus.axiov) begin
        if (exp_q.size() == 0) check("extra_dibit", 1, 0);
        else check("dibit", bus.axiod, exp_q.pop_front());
      end
      if (bus.row_rd_en) begin
        if (bus.row_addr == 1) rd1_c = cyc;
        check("rd_addr", bus.row_addr, rd_exp);
        rd_exp++;
      end
    end
  end

  task automatic fill(input int mode);
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++)
        mem[r][k] = mode == 0 ? E'(r * D + k) :
                    mode == 1 ? (r == 0 ? (k == 0 ? E'(8'hC6) : '0) : E'($urandom)) :
                    mode == 2 ? E'($urandom) :
                    mode == 3 ? E'(1) :
                    mode == 4 ? E'(3) :
                    (r == 5 && k == 7 ? E'(5) : '0);
  endtask

  task automatic push_expected();
    int sum = 0;
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin
        sum += int'(mem[r][k]);
        for (int d = DPE - 1; d >= 0; d--) exp_q.push_back(2'(mem[r][k] >> (2 * d)));
      end
`ifdef MATRIX_SENDER_CHECKSUM_EN
    for (int d = 3; d >= 0; d--) exp_q.push_back(2'((sum % 256) >> (2 * d)));
`endif
  endtask

  task automatic run(input int restart_at, input int rst_at, input bit chk_order);
    int t0, total, nv = 0, nd = 0;
    int first_c = -1, last_c = -1, done_c = -1;
    bit busy_bad = 0, busy_at_done = 1;
    logic [1:0] f4[4];
    exp_q.delete();
    push_expected();
    total = exp_q.size();
    rd_exp = 0;
    rd1_c = -1;
    @(negedge eth_refclk);
    bus.start = 1'b1;
    t0 = cyc + 1;
    @(negedge eth_refclk);
    bus.start = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (bus.axiov) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (nv < 4) f4[nv] = bus.axiod;
        nv++;
        if (!bus.busy) busy_bad = 1;
      end
      if (bus.done) begin
        nd++;
        if (done_c < 0) begin
          done_c = cyc;
          busy_at_done = bus.busy;
        end
      end
      if (rst_at > 0 && nv >= rst_at) break;
      if (done_c >= 0 && cyc > done_c + 3) break;
      bus.start = restart_at > 0 && nv == restart_at;
      @(negedge eth_refclk);
    end
    bus.start = 1'b0;
    if (rst_at > 0) begin
      check("rst_point_reached", nv >= rst_at, 1);
      rst = 1'b1;
      @(negedge eth_refclk);
      check("rst_axiov", bus.axiov, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge eth_refclk);
      return;
    end
    check("first_latency", first_c - t0, LAT + 2);
    check("valid_count", nv, total);
    check("contiguous_span", last_c - first_c + 1, total);
    check("done_pulses", nd, 1);
    check("done_after_last", done_c, last_c + 1);
    check("busy_at_done", busy_at_done, 0);
    check("busy_while_valid", busy_bad, 0);
    check("read_count", rd_exp, D);
    check("prefetch_row1_timing", rd1_c == first_c - 1 || rd1_c == first_c, 1);
    check("queue_drained", exp_q.size(), 0);
    if (chk_order) begin
      check("order_d0", f4[0], 2'b11);
      check("order_d1", f4[1], 2'b00);
      check("order_d2", f4[2], 2'b01);
      check("order_d3", f4[3], 2'b10);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) mem[r][k] = '0;
    repeat (3) @(negedge eth_refclk);
    check("reset_axiov", bus.axiov, 0);
    check("reset_axiod", bus.axiod, 0);
    check("reset_rd_en", bus.row_rd_en, 0);
    check("reset_addr", bus.row_addr, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b0;
    @(negedge eth_refclk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge eth_refclk);
    check("start_rst_busy", bus.busy, 0);
    check("start_rst_rd_en", bus.row_rd_en, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge eth_refclk);
    check("start_rst_no_latch", bus.busy, 0);
    fill(0);
    run(0, 0, 0);
    fill(1);
    run(0, 0, 1);
    fill(2);
    run(1000, 0, 0);
    fill(2);
    run(0, 2000, 0);
    fill(2);
    run(0, 0, 0);
`ifdef MATRIX_SENDER_CHECKSUM_EN
    fill(3);
    run(0, 0, 0);
    fill(4);
    run(0, 0, 0);
    fill(5);
    run(0, 0, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
